// File: rtl/dff_output_monitor.sv
// -----------------------------------------------------------------------------
// dff_output_monitor
//
// Watches the complementary q/qbar outputs of an upstream D flip-flop stage.
// Produces registered rise/fall pulses, a saturating toggle count, a sticky
// complement-violation flag, and a stuck indication when q has not toggled
// within a programmable number of cycles.
//
// Optional feature macro: DFF_MON_HIST_EN
//   When defined, adds the output port 'hist', a HIST_D-deep shift register
//   of the synchronised q sample that advances on every TRACK cycle.
//
// Parameters
//   CNT_W    width of toggle_cnt (saturates at all-ones)
//   STUCK_W  width of the idle-cycle counter and of stuck_limit
//   HIST_D   depth of the sample history (DFF_MON_HIST_EN only), >= 2
//
// Ports
//   clk          in   clock, all logic on the rising edge
//   rst_n        in   synchronous reset, active low
//   en           in   monitor enable
//   q_in         in   q output of the DFF stage
//   qbar_in      in   qbar output of the DFF stage
//   stuck_limit  in   idle cycles before stuck is declared, 0 = disabled
//   clr_err      in   clears comp_err and leaves FAULT
//   rise_pulse   out  one-cycle pulse per detected 0->1 on q
//   fall_pulse   out  one-cycle pulse per detected 1->0 on q
//   toggle_cnt   out  saturating count of detected edges
//   stuck        out  no edge seen for stuck_limit TRACK cycles
//   comp_err     out  sticky q==qbar violation
//   mon_state    out  IDLE=0, ARMED=1, TRACK=2, FAULT=3
//   hist         out  sample history (DFF_MON_HIST_EN only)
// -----------------------------------------------------------------------------
module dff_output_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned STUCK_W = 16,
  parameter int unsigned HIST_D  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               q_in,
  input  logic               qbar_in,
  input  logic [STUCK_W-1:0] stuck_limit,
  input  logic               clr_err,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic [CNT_W-1:0]   toggle_cnt,
  output logic               stuck,
  output logic               comp_err,
  output logic [1:0]         mon_state
`ifdef DFF_MON_HIST_EN
  ,
  output logic [HIST_D-1:0]  hist
`endif
);

  if (CNT_W < 1 || STUCK_W < 1 || HIST_D < 2) begin : g_bad_params
    $error("dff_output_monitor: CNT_W and STUCK_W must be >= 1, HIST_D >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [STUCK_W-1:0] IDLE_ONE = STUCK_W'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic               r_q_s;
  logic               r_qbar_s;
  logic               r_q_p;
  logic               r_rise;
  logic               r_fall;
  logic [CNT_W-1:0]   r_toggle_cnt;
  logic [STUCK_W-1:0] r_idle_cnt;
  logic               r_stuck;
  logic               r_comp_err;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic               w_edge;
  logic               w_viol;
  logic               w_viol_chk;
  logic [CNT_W-1:0]   w_toggle_inc;
  logic [STUCK_W-1:0] w_idle_inc;
  logic               w_stuck_hit;
  logic               w_rise_nxt;
  logic               w_fall_nxt;
  logic [CNT_W-1:0]   w_toggle_nxt;
  logic [STUCK_W-1:0] w_idle_nxt;
  logic               w_stuck_nxt;
  logic               w_comp_nxt;

  // Edge and complement checks both work on the synchronised samples, so the
  // reported edge is the one between the last two sampled q values.
  assign w_edge     = r_q_s ^ r_q_p;
  assign w_viol     = ~(r_q_s ^ r_qbar_s);
  // The complement check is live in every state except IDLE. In FAULT it only
  // matters for blocking a clear that coincides with a fresh violation.
  assign w_viol_chk = w_viol && (r_state != ST_IDLE);

  assign w_toggle_inc = (r_toggle_cnt == '1) ? r_toggle_cnt : r_toggle_cnt + CNT_ONE;
  assign w_idle_inc   = (r_idle_cnt == '1)   ? r_idle_cnt   : r_idle_cnt + IDLE_ONE;
  // Compared against the post-increment count so stuck is visible in the
  // same cycle that idle_cnt reaches the limit.
  assign w_stuck_hit  = (stuck_limit != '0) && (w_idle_inc >= stuck_limit);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_viol_chk) begin
          w_state_nxt = ST_FAULT;
        end else if (!en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_viol_chk) begin
          w_state_nxt = ST_FAULT;
        end else if (!en) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: begin
        // A clear arriving together with a new violation is ignored.
        if (clr_err && !w_viol_chk) begin
          w_state_nxt = en ? ST_ARMED : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_toggle_nxt = r_toggle_cnt;
    w_idle_nxt   = r_idle_cnt;
    w_stuck_nxt  = r_stuck;
    w_comp_nxt   = r_comp_err;

    case (r_state)
      ST_IDLE, ST_ARMED: begin
        // ARMED only takes the reference sample; any apparent edge is dropped.
        w_idle_nxt  = '0;
        w_stuck_nxt = 1'b0;
      end
      ST_TRACK: begin
        if (!w_viol_chk) begin
          if (!en) begin
            w_idle_nxt  = '0;
            w_stuck_nxt = 1'b0;
          end else if (w_edge) begin
            // An edge always beats the stuck limit being reached.
            w_rise_nxt   = r_q_s;
            w_fall_nxt   = ~r_q_s;
            w_toggle_nxt = w_toggle_inc;
            w_idle_nxt   = '0;
            w_stuck_nxt  = 1'b0;
          end else begin
            w_idle_nxt  = w_idle_inc;
            w_stuck_nxt = w_stuck_hit;
          end
        end
      end
      default: begin
        // FAULT: pulses stay low, counters and stuck hold.
      end
    endcase

    // Set dominates clear for the sticky error.
    if (w_viol_chk) begin
      w_comp_nxt = 1'b1;
    end else if (clr_err) begin
      w_comp_nxt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sampling and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_s        <= 1'b0;
      r_qbar_s     <= 1'b1;
      r_q_p        <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_toggle_cnt <= '0;
      r_idle_cnt   <= '0;
      r_stuck      <= 1'b0;
      r_comp_err   <= 1'b0;
    end else begin
      r_q_s        <= q_in;
      r_qbar_s     <= qbar_in;
      r_q_p        <= r_q_s;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
      r_toggle_cnt <= w_toggle_nxt;
      r_idle_cnt   <= w_idle_nxt;
      r_stuck      <= w_stuck_nxt;
      r_comp_err   <= w_comp_nxt;
    end
  end

`ifdef DFF_MON_HIST_EN
  logic [HIST_D-1:0] r_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (r_state == ST_TRACK) begin
      r_hist <= {r_hist[HIST_D-2:0], r_q_s};
    end
  end

  assign hist = r_hist;
`endif

  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign toggle_cnt = r_toggle_cnt;
  assign stuck      = r_stuck;
  assign comp_err   = r_comp_err;
  assign mon_state  = r_state;

endmodule

// File: tb/tb_dff_output_monitor.sv
module tb_dff_output_monitor;

  localparam int CNT_W   = 4;
  localparam int STUCK_W = 6;
  localparam int HIST_D  = 8;

  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int IDLE_MAX = (1 << STUCK_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_TRACK = 2;
  localparam int M_FAULT = 3;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               q_in;
  logic               qbar_in;
  logic [STUCK_W-1:0] stuck_limit;
  logic               clr_err;
  logic               rise_pulse;
  logic               fall_pulse;
  logic [CNT_W-1:0]   toggle_cnt;
  logic               stuck;
  logic               comp_err;
  logic [1:0]         mon_state;
`ifdef DFF_MON_HIST_EN
  logic [HIST_D-1:0]  hist;
`endif

  dff_output_monitor #(
    .CNT_W  (CNT_W),
    .STUCK_W(STUCK_W),
    .HIST_D (HIST_D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .q_in       (q_in),
    .qbar_in    (qbar_in),
    .stuck_limit(stuck_limit),
    .clr_err    (clr_err),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .toggle_cnt (toggle_cnt),
    .stuck      (stuck),
    .comp_err   (comp_err),
    .mon_state  (mon_state)
`ifdef DFF_MON_HIST_EN
    ,
    .hist       (hist)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the raw input samples seen at the last two edges, and the
  // externally visible quantities as plain integers.
  int m_samp_q [2];
  int m_samp_qb;
  int m_mode;
  int m_rise, m_fall, m_tc, m_idle, m_stuck, m_ce, m_hist;

  task automatic model_reset();
    m_samp_q[0] = 0; m_samp_q[1] = 0; m_samp_qb = 1;
    m_rise = 0; m_fall = 0; m_tc = 0; m_idle = 0; m_stuck = 0; m_ce = 0;
    m_hist = 0; m_mode = M_IDLE;
  endtask

  task automatic model_edge();
    int  cur, prev, nxt;
    bit  changed, bad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cur = m_samp_q[0];
    prev = m_samp_q[1];
    changed = (cur != prev);
    bad = (cur == m_samp_qb) && (m_mode != M_IDLE);
    m_rise = 0;
    m_fall = 0;
    nxt = m_mode;
    if (m_mode == M_TRACK) m_hist = ((m_hist * 2) + cur) % (1 << HIST_D);
    if (m_mode == M_IDLE || m_mode == M_ARMED) begin
      m_idle = 0;
      m_stuck = 0;
    end
    if (bad) begin
      m_ce = 1;
      nxt = M_FAULT;
    end else begin
      if (clr_err) m_ce = 0;
      if (m_mode == M_IDLE) nxt = en ? M_ARMED : M_IDLE;
      else if (m_mode == M_ARMED) nxt = en ? M_TRACK : M_IDLE;
      else if (m_mode == M_FAULT) begin
        if (clr_err) nxt = en ? M_ARMED : M_IDLE;
      end else if (!en) begin
        nxt = M_IDLE;
        m_idle = 0;
        m_stuck = 0;
      end else if (changed) begin
        if (cur == 1) m_rise = 1; else m_fall = 1;
        if (m_tc < CNT_MAX) m_tc++;
        m_idle = 0;
        m_stuck = 0;
      end else begin
        if (m_idle < IDLE_MAX) m_idle++;
        m_stuck = (stuck_limit != 0 && m_idle >= int'(stuck_limit)) ? 1 : 0;
      end
    end
    m_mode = nxt;
    m_samp_q[1] = m_samp_q[0];
    m_samp_q[0] = int'(q_in);
    m_samp_qb = int'(qbar_in);
  endtask

  // One clock: advance model at the edge, compare all outputs shortly after.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rise_pulse", 32'(rise_pulse), m_rise);
    check("fall_pulse", 32'(fall_pulse), m_fall);
    check("toggle_cnt", 32'(toggle_cnt), m_tc);
    check("stuck",      32'(stuck),      m_stuck);
    check("comp_err",   32'(comp_err),   m_ce);
    check("mon_state",  32'(mon_state),  m_mode);
`ifdef DFF_MON_HIST_EN
    check("hist",       32'(hist),       m_hist);
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; en = 1'b0; q_in = 1'b1; qbar_in = 1'b0;
    stuck_limit = '0; clr_err = 1'b0;

    // Reset values with q_in=1 held at the input
    steps(3);
    check("rst_rise",  32'(rise_pulse), 0);
    check("rst_tc",    32'(toggle_cnt), 0);
    check("rst_state", 32'(mon_state),  0);
    check("rst_ce",    32'(comp_err),   0);
    rst_n = 1'b1;
    steps(3);
    check("idle_hold", 32'(mon_state), 0);

    // Single rise and fall
    q_in = 1'b0; qbar_in = 1'b1; en = 1'b1;
    steps(4);
    check("tracking", 32'(mon_state), 2);
    q_in = 1'b1; qbar_in = 1'b0;
    step();
    check("rise_lat1", 32'(rise_pulse), 0);
    step();
    check("rise_lat2", 32'(rise_pulse), 1);
    check("rise_cnt",  32'(toggle_cnt), 1);
    step();
    check("rise_once", 32'(rise_pulse), 0);
    q_in = 1'b0; qbar_in = 1'b1;
    steps(2);
    check("fall_seen", 32'(fall_pulse), 1);
    check("fall_cnt",  32'(toggle_cnt), 2);

    // Saturation
    for (int i = 0; i < 20; i++) begin
      q_in = ~q_in; qbar_in = ~q_in;
      step();
    end
    step();
    check("sat_cnt",   32'(toggle_cnt), CNT_MAX);
    check("sat_pulse", 32'(rise_pulse | fall_pulse), 1);

    // Stuck detection
    stuck_limit = 6'd5;
    steps(12);
    check("stuck_set", 32'(stuck), 1);
    q_in = ~q_in; qbar_in = ~q_in;
    steps(2);
    check("stuck_clr",   32'(stuck), 0);
    check("stuck_pulse", 32'(rise_pulse | fall_pulse), 1);
    stuck_limit = '0;
    steps(20);
    check("stuck_off", 32'(stuck), 0);

    // Complement fault with coincident clear
    q_in = 1'b1; qbar_in = 1'b1;
    step();
    q_in = 1'b1; qbar_in = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("fault_ce",    32'(comp_err), 1);
    check("fault_state", 32'(mon_state), 3);
    check("fault_nop",   32'(rise_pulse | fall_pulse), 0);
    en = 1'b0;
    steps(3);
    check("fault_hold", 32'(mon_state), 3);
    en = 1'b1; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_armed", 32'(mon_state), 1);
    step();
    check("clr_track", 32'(mon_state), 2);
    check("clr_ce",    32'(comp_err), 0);

    // Reset in FAULT together with clr_err, then first-sample suppression
    q_in = 1'b0; qbar_in = 1'b0;
    step();
    q_in = 1'b0; qbar_in = 1'b1;
    step();
    check("fault2", 32'(mon_state), 3);
    rst_n = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("mrst_tc",    32'(toggle_cnt), 0);
    check("mrst_ce",    32'(comp_err),   0);
    check("mrst_state", 32'(mon_state),  0);
`ifdef DFF_MON_HIST_EN
    check("mrst_hist",  32'(hist), 0);
`endif
    q_in = 1'b1; qbar_in = 1'b0;
    step();
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_first_rise", 32'(rise_pulse), 0);
    end

    // Randomised phases with varying toggle density, limits and disturbances
    for (int blk = 0; blk < 25; blk++) begin
      int pct;
      pct = (blk % 5 == 4) ? 0 : int'($urandom_range(90, 5));
      stuck_limit = (blk % 7 == 3) ? 6'd63 : 6'($urandom_range(12, 0));
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(99, 0) < pct) q_in = ~q_in;
        qbar_in = ($urandom_range(99, 0) < 3) ? q_in : ~q_in;
        en      = ($urandom_range(99, 0) < 92);
        clr_err = ($urandom_range(99, 0) < 6);
        rst_n   = ($urandom_range(199, 0) != 0);
        if (pct == 0) begin
          qbar_in = ~q_in; en = 1'b1; clr_err = 1'b1; rst_n = 1'b1;
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
